// File: rtl/uart_rx_frame_counter.sv
// Oversampling position counter for a UART receiver: tracks the edge within a bit and
// the bit within a frame, and raises mid-bit sample strobes and bit/frame end strobes.
module uart_rx_frame_counter #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [1:0]            data_len,
  input  logic                  par_en,
  input  logic                  stop2,
  input  logic                  edge_cnt_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  sample_en,
  output logic                  sample_last,
  output logic                  bit_end,
  output logic                  frame_end,
  output logic                  cfg_err,
  output logic                  state_dbg
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;
  localparam int         CW    = PRESCALE_W + 1;

  logic [0:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  err_q, err_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic [1:0]            dl_q, dl_d;
  logic                  pe_q, pe_d;
  logic                  s2_q, s2_d;

  // One extra bit keeps ps-1, h-1 and h+1 free of wrap-around.
  logic [CW-1:0]    ps_x, ps_m1, half, edge_x;
  logic [BIT_W-1:0] last_bit;
  logic             in_count, prescale_ok, bit_end_w, at_last_bit;

  always_comb begin
    ps_x        = {1'b0, ps_q};
    ps_m1       = ps_x - CW'(1);
    half        = ps_x >> 1;
    edge_x      = {1'b0, edge_q};
    last_bit    = BIT_W'(dl_q) + BIT_W'(pe_q) + BIT_W'(s2_q) + BIT_W'(6);
    in_count    = (state_q == COUNT);
    prescale_ok = ({1'b0, Prescale} >= CW'(4));
    bit_end_w   = in_count && (edge_x == ps_m1);
    at_last_bit = (bit_q == last_bit);
  end

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    err_d   = err_q;
    ps_d    = ps_q;
    dl_d    = dl_q;
    pe_d    = pe_q;
    s2_d    = s2_q;
    if (!edge_cnt_en) begin
      state_d = IDLE;
      edge_d  = '0;
      bit_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          edge_d = '0;
          bit_d  = '0;
          if (prescale_ok) begin
            ps_d    = Prescale;
            dl_d    = data_len;
            pe_d    = par_en;
            s2_d    = stop2;
            edge_d  = PRESCALE_W'(1);
            err_d   = 1'b0;
            state_d = COUNT;
          end else begin
            err_d = 1'b1;
          end
        end
        COUNT: begin
          if (bit_end_w) begin
            edge_d = '0;
            if (at_last_bit) begin
              bit_d = '0;
              // Back-to-back frame: pick up the live configuration, but never an
              // illegal Prescale -- that drops to IDLE with the error flag set.
              if (prescale_ok) begin
                ps_d = Prescale;
                dl_d = data_len;
                pe_d = par_en;
                s2_d = stop2;
              end else begin
                state_d = IDLE;
                err_d   = 1'b1;
              end
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            edge_d = edge_q + PRESCALE_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      err_q   <= 1'b0;
      ps_q    <= '0;
      dl_q    <= '0;
      pe_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      ps_q    <= ps_d;
      dl_q    <= dl_d;
      pe_q    <= pe_d;
      s2_q    <= s2_d;
    end
  end

  always_comb begin
    edge_cnt    = edge_q;
    bit_cnt     = bit_q;
    cfg_err     = err_q;
    state_dbg   = state_q[0];
    sample_en   = in_count && ((edge_x == half - CW'(1)) || (edge_x == half) ||
                               (edge_x == half + CW'(1)));
    sample_last = in_count && (edge_x == half + CW'(1));
    bit_end     = bit_end_w;
    frame_end   = bit_end_w && at_last_bit;
  end

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Bench for uart_rx_frame_counter: a frame-position model checked every cycle, plus
// directed scenarios with hand-computed frame lengths and strobe positions.
module tb_uart_rx_frame_counter;
  localparam int PW = 6;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] prescale = PW'(8);
  logic [1:0]    data_len = 2'd3;
  logic          par_en = 1'b0;
  logic          stop2 = 1'b0;
  logic          en = 1'b0;

  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sample_en, sample_last, bit_end, frame_end, cfg_err, state_dbg;

  uart_rx_frame_counter #(.PRESCALE_W(PW), .BIT_W(BW)) dut (
    .CLK(clk), .RST(rst_n), .Prescale(prescale), .data_len(data_len),
    .par_en(par_en), .stop2(stop2), .edge_cnt_en(en),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sample_en(sample_en),
    .sample_last(sample_last), .bit_end(bit_end), .frame_end(frame_end),
    .cfg_err(cfg_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit check_on = 1'b0;

  // Model: a frame is a linear run of ps*fl clocks; position p maps to (bit, edge).
  bit m_active = 1'b0;
  bit m_err = 1'b0;
  int m_ps = 0;
  int m_fl = 0;
  int m_p = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_err = 1'b0; m_ps = 0; m_fl = 0; m_p = 0;
    end else if (!en) begin
      m_active = 1'b0; m_err = 1'b0; m_p = 0;
    end else if (!m_active) begin
      if (int'(prescale) >= 4) begin
        m_ps = int'(prescale);
        m_fl = 1 + (int'(data_len) + 5) + int'(par_en) + (1 + int'(stop2));
        m_active = 1'b1; m_p = 1; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_p = m_p + 1;
      if (m_p == m_ps * m_fl) begin
        m_p = 0;
        if (int'(prescale) >= 4) begin
          m_ps = int'(prescale);
          m_fl = 1 + (int'(data_len) + 5) + int'(par_en) + (1 + int'(stop2));
        end else begin
          m_active = 1'b0; m_err = 1'b1;
        end
      end
    end
  end

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (check_on) begin
      int e, b, h;
      logic [15:0] exp_v, act_v;
      bit se, sl, be, fe;
      e = 0; b = 0; se = 0; sl = 0; be = 0; fe = 0;
      if (m_active) begin
        e  = m_p % m_ps;
        b  = m_p / m_ps;
        h  = m_ps / 2;
        se = (e == h - 1) || (e == h) || (e == h + 1);
        sl = (e == h + 1);
        be = (e == m_ps - 1);
        fe = be && (b == m_fl - 1);
      end
      exp_v = {PW'(e), BW'(b), se, sl, be, fe, m_err, m_active};
      act_v = {edge_cnt, bit_cnt, sample_en, sample_last, bit_end, frame_end, cfg_err, state_dbg};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t actual=%h expected=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Counts falling edges (current one included) until frame_end; -1 on timeout.
  task automatic wait_fe(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      n++;
      if (frame_end === 1'b1) return;
      @(negedge clk);
    end
    n = -1;
  endtask

  task automatic set_cfg(input int ps, input int dl, input int pe, input int s2);
    prescale = PW'(ps);
    data_len = 2'(dl);
    par_en   = 1'(pe);
    stop2    = 1'(s2);
  endtask

  task automatic stop_and_idle();
    en = 1'b0;
    @(negedge clk);
  endtask

  int n;
  int t_ps[4] = '{4, 9, 63, 5};
  int t_dl[4] = '{0, 1, 3, 2};
  int t_pe[4] = '{0, 1, 1, 0};
  int t_s2[4] = '{0, 0, 1, 1};
  int t_n[4]  = '{28, 81, 756, 50};

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {edge_cnt, bit_cnt, sample_en, sample_last, bit_end,
                            frame_end, cfg_err, state_dbg}, 0);
    check_on = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // 8 clocks/bit, 8 data bits, no parity, 1 stop -> 10 bits
    set_cfg(8, 3, 0, 0);
    en = 1'b1;
    wait_fe(n);
    check("t1_frame_end_clock", n, 80);
    check("t1_last_bit", bit_cnt, 9);
    check("t1_last_edge", edge_cnt, 7);
    @(negedge clk);
    check("t1_wrap_bit", bit_cnt, 0);
    check("t1_wrap_edge", edge_cnt, 0);
    check("t1_still_count", state_dbg, 1);
    repeat (3) @(negedge clk);
    check("t1_sample_at3", {sample_en, sample_last}, 2'b10);
    repeat (2) @(negedge clk);
    check("t1_sample_last_at5", {sample_en, sample_last}, 2'b11);
    stop_and_idle();

    // 16 clocks/bit, 7 data, parity, 2 stop -> 11 bits
    set_cfg(16, 2, 1, 1);
    en = 1'b1;
    wait_fe(n);
    check("t2_frame_end_clock", n, 176);
    check("t2_last_bit", bit_cnt, 10);
    stop_and_idle();

    // Prescale changed mid-frame only takes effect on the next frame
    set_cfg(8, 3, 0, 0);
    en = 1'b1;
    repeat (34) @(negedge clk);
    prescale = PW'(16);
    wait_fe(n);
    check("t3_remaining_clocks", n, 46);
    @(negedge clk);
    wait_fe(n);
    check("t3_next_frame_clocks", n, 160);
    stop_and_idle();

    // Enable dropped at bit 3 edge 5
    set_cfg(8, 3, 0, 0);
    en = 1'b1;
    repeat (29) @(negedge clk);
    check("t4_pos_before_drop", {bit_cnt, edge_cnt}, {BW'(3), PW'(5)});
    check("t4_strobes_before_drop", {sample_en, sample_last}, 2'b11);
    en = 1'b0;
    @(negedge clk);
    check("t4_after_drop", {edge_cnt, bit_cnt, sample_en, sample_last, bit_end,
                            frame_end, state_dbg}, 0);
    en = 1'b1;
    wait_fe(n);
    check("t4_restart_frame", n, 80);
    stop_and_idle();

    // Illegal prescale then legal
    prescale = PW'(2);
    en = 1'b1;
    @(negedge clk);
    check("t5_err_set", {cfg_err, state_dbg, edge_cnt}, {1'b1, 1'b0, PW'(0)});
    prescale = PW'(3);
    @(negedge clk);
    check("t5_err_at3", {cfg_err, state_dbg, edge_cnt}, {1'b1, 1'b0, PW'(0)});
    prescale = PW'(8);
    @(negedge clk);
    check("t5_err_clear_start", {cfg_err, state_dbg, edge_cnt}, {1'b0, 1'b1, PW'(1)});
    stop_and_idle();

    // Asynchronous reset at bit 6, between clock edges
    set_cfg(8, 3, 0, 0);
    en = 1'b1;
    repeat (50) @(negedge clk);
    check("t6_pos_before_reset", bit_cnt, 6);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_reset", {edge_cnt, bit_cnt, sample_en, sample_last, bit_end,
                             frame_end, cfg_err, state_dbg}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fe(n);
    check("t6_restart_frame", n, 80);
    stop_and_idle();

    // Configuration table incl. minimum and maximum prescale
    for (int i = 0; i < 4; i++) begin
      set_cfg(t_ps[i], t_dl[i], t_pe[i], t_s2[i]);
      en = 1'b1;
      wait_fe(n);
      check($sformatf("t7_frame_clocks_%0d", i), n, t_n[i]);
      @(negedge clk);
      wait_fe(n);
      check($sformatf("t7_b2b_clocks_%0d", i), n, t_n[i]);
      stop_and_idle();
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
